// File: rtl/fault_monitor_n_pkg.sv
// Shared defaults, first-fault cause codes and filter modes for fault_monitor_n.
package fault_mon_pkg;

   localparam int NCH_DEF           = 4;
   localparam int FILT_LEN_DEF      = 8;
   localparam int WDOG_MAX_DEF      = 400;
   localparam int SYNC_MISS_MAX_DEF = 4;
   localparam int CHK_BASE_DEF      = 5000;
   localparam int CHK_STEP_DEF      = 10000;

   typedef enum logic [3:0] {
      FC_NONE = 4'd0,
      FC_CALL = 4'd1,
      FC_OV   = 4'd2,
      FC_TEM  = 4'd3,
      FC_CH0  = 4'd4
   } first_code_e;

   typedef enum logic {
      FILT_LATCH  = 1'b0,
      FILT_UPDOWN = 1'b1
   } filt_mode_e;

   // Lowest code wins when several sources are active together.
   function automatic logic [3:0] first_code_enc(input logic i_call, input logic i_ov,
                                                 input logic i_tem, input logic [7:0] i_ch);
      logic [3:0] code;
      code = FC_NONE;
      for (int k = 7; k >= 0; k--) begin
         if (i_ch[k]) code = FC_CH0 + 4'(k);
      end
      if (i_tem)  code = FC_TEM;
      if (i_ov)   code = FC_OV;
      if (i_call) code = FC_CALL;
      return code;
   endfunction

endpackage

// File: rtl/fault_monitor_n_if.sv
// Alarm inputs and fault outputs of fault_monitor_n; master drives inputs, slave is the monitor.
interface fault_monitor_n_if #(parameter int NCH = fault_mon_pkg::NCH_DEF);

   logic           start, check, syn, rcvd, clr_fault;
   logic [15:0]    tri_cnt, fre_data, check_data;
   logic [NCH-1:0] tr, col;
   logic           ov, uv, tem, db;

   logic [NCH-1:0] ch_fault;
   logic           call_fault, ov_fault, uv_fault, tem_fault, db_fault, fault;
   logic [3:0]     first_code;

   modport master (
      output start, check, syn, rcvd, clr_fault, tri_cnt, fre_data, check_data,
             tr, col, ov, uv, tem, db,
      input  ch_fault, call_fault, ov_fault, uv_fault, tem_fault, db_fault, fault, first_code
   );

   modport slave (
      input  start, check, syn, rcvd, clr_fault, tri_cnt, fre_data, check_data,
             tr, col, ov, uv, tem, db,
      output ch_fault, call_fault, ov_fault, uv_fault, tem_fault, db_fault, fault, first_code
   );

endinterface

// File: rtl/fault_monitor_n_filter.sv
// Alarm qualification filter: FILT_LATCH holds once qualified (clearable when input idle),
// FILT_UPDOWN is a saturating up/down integrator with hysteresis at 0 and LEN.
module fm_filter import fault_mon_pkg::*; #(
   parameter filt_mode_e MODE = FILT_LATCH,
   parameter int         LEN  = FILT_LEN_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic i_in,
   input  logic i_clr,
   output logic o_out
);

   localparam int            CW    = $clog2(LEN + 1);
   localparam logic [CW-1:0] LEN_C = CW'(LEN);

   logic [CW-1:0] r_cnt, w_cnt_nxt;
   logic          r_out, w_out_nxt;

   always_comb begin
      // NOTE: every comb output gets a default first so no path infers a latch.
      w_cnt_nxt = r_cnt;
      w_out_nxt = r_out;
      if (MODE == FILT_LATCH) begin
         if (i_in) begin
            if (r_cnt != LEN_C) w_cnt_nxt = r_cnt + 1'b1;
            if (w_cnt_nxt == LEN_C) w_out_nxt = 1'b1;
         end else begin
            w_cnt_nxt = '0;
            if (i_clr) w_out_nxt = 1'b0;
         end
      end else begin
         if (i_in) begin
            if (r_cnt != LEN_C) w_cnt_nxt = r_cnt + 1'b1;
         end else if (r_cnt != '0) begin
            w_cnt_nxt = r_cnt - 1'b1;
         end
         if (w_cnt_nxt == LEN_C)   w_out_nxt = 1'b1;
         else if (w_cnt_nxt == '0) w_out_nxt = 1'b0;
      end
   end

   // NOTE: state updates use non-blocking assignment; reset is in the sensitivity list (async).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
         r_out <= 1'b0;
      end else begin
         r_cnt <= w_cnt_nxt;
         r_out <= w_out_nxt;
      end
   end

   assign o_out = r_out;

endmodule

// File: rtl/fault_monitor_n.sv
// Converter fault monitor: switch/alarm filters, comm watchdog, first-fault capture.
// Optional channel self-check under `define FAULT_MON_SELFTEST_EN.
module fault_monitor_n import fault_mon_pkg::*; #(
   parameter int NCH           = NCH_DEF,
   parameter int FILT_LEN      = FILT_LEN_DEF,
   parameter int WDOG_MAX      = WDOG_MAX_DEF,
   parameter int SYNC_MISS_MAX = SYNC_MISS_MAX_DEF,
   parameter int CHK_BASE      = CHK_BASE_DEF,
   parameter int CHK_STEP      = CHK_STEP_DEF
) (
   input  logic clk,
   input  logic rst,
   fault_monitor_n_if.slave bus
);

   localparam int             WCW    = $clog2(WDOG_MAX + 1);
   localparam int             MCW    = $clog2(SYNC_MISS_MAX + 1);
   localparam logic [WCW-1:0] WDOG_C = WCW'(WDOG_MAX);
   localparam logic [MCW-1:0] MISS_C = MCW'(SYNC_MISS_MAX);

   logic           r_ready, r_syn_seen, r_call, r_fault_q;
   logic [WCW-1:0] r_rcvd_cnt;
   logic [MCW-1:0] r_miss_cnt;
   logic [3:0]     r_code;
   logic           w_match, w_syn_since, w_call_cause, w_fault;
   logic           w_ov, w_uv, w_tem, w_db;
   logic [NCH-1:0] w_tr_flt, w_ch_fault;
   logic [3:0]     w_code_now;

   assign w_match      = r_ready && (bus.tri_cnt == bus.fre_data);
   assign w_syn_since  = r_syn_seen | bus.syn;
   assign w_call_cause = (r_rcvd_cnt == WDOG_C) || (r_miss_cnt == MISS_C);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ready    <= 1'b0;
         r_rcvd_cnt <= '0;
         r_miss_cnt <= '0;
         r_syn_seen <= 1'b0;
         r_call     <= 1'b0;
      end else begin
         if (bus.syn | bus.start | bus.check) r_ready <= 1'b1;

         if (!r_ready || !bus.rcvd)  r_rcvd_cnt <= '0;
         else if (r_rcvd_cnt != WDOG_C) r_rcvd_cnt <= r_rcvd_cnt + 1'b1;

         // A syn in the matching cycle itself still counts as seen for that period.
         if (w_match) begin
            r_syn_seen <= 1'b0;
            if (w_syn_since)                r_miss_cnt <= '0;
            else if (r_miss_cnt != MISS_C) r_miss_cnt <= r_miss_cnt + 1'b1;
         end else begin
            r_syn_seen <= w_syn_since;
         end

         if (w_call_cause)       r_call <= 1'b1;
         else if (bus.clr_fault) r_call <= 1'b0;
      end
   end

   for (genvar k = 0; k < NCH; k++) begin : g_tr
      fm_filter #(.MODE(FILT_LATCH), .LEN(FILT_LEN)) u_tr_flt (
         .clk(clk), .rst(rst), .i_in(~bus.tr[k]), .i_clr(bus.clr_fault), .o_out(w_tr_flt[k])
      );
   end

   fm_filter #(.MODE(FILT_LATCH), .LEN(FILT_LEN)) u_ov_flt (
      .clk(clk), .rst(rst), .i_in(bus.ov), .i_clr(bus.clr_fault), .o_out(w_ov)
   );
   fm_filter #(.MODE(FILT_LATCH), .LEN(FILT_LEN)) u_tem_flt (
      .clk(clk), .rst(rst), .i_in(bus.tem), .i_clr(bus.clr_fault), .o_out(w_tem)
   );
   fm_filter #(.MODE(FILT_UPDOWN), .LEN(FILT_LEN)) u_uv_flt (
      .clk(clk), .rst(rst), .i_in(bus.uv), .i_clr(bus.clr_fault), .o_out(w_uv)
   );
   fm_filter #(.MODE(FILT_UPDOWN), .LEN(FILT_LEN)) u_db_flt (
      .clk(clk), .rst(rst), .i_in(bus.db), .i_clr(bus.clr_fault), .o_out(w_db)
   );

`ifdef FAULT_MON_SELFTEST_EN
   logic [NCH-1:0] r_st_fault, w_st_set;

   // At sample point k only switch k may report collector current.
   always_comb begin
      w_st_set = '0;
      for (int k = 0; k < NCH; k++) begin
         if (int'(bus.check_data) == CHK_BASE + k * CHK_STEP) begin
            for (int j = 0; j < NCH; j++) begin
               if (j == k) w_st_set[j] = w_st_set[j] | bus.col[j];
               else        w_st_set[j] = w_st_set[j] | ~bus.col[j];
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_st_fault <= '0;
      else     r_st_fault <= w_st_set | (r_st_fault & ~{NCH{bus.clr_fault}});
   end

   assign w_ch_fault = w_tr_flt | r_st_fault;
`else
   logic w_unused_ok;
   assign w_unused_ok = ^{bus.col, bus.check_data, CHK_BASE[0], CHK_STEP[0]};
   assign w_ch_fault  = w_tr_flt;
`endif

   assign w_fault    = r_call | w_ov | w_tem | (|w_ch_fault);
   assign w_code_now = first_code_enc(r_call, w_ov, w_tem, 8'(w_ch_fault));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_fault_q <= 1'b0;
         r_code    <= FC_NONE;
      end else begin
         r_fault_q <= w_fault;
         if (!w_fault)        r_code <= FC_NONE;
         else if (!r_fault_q) r_code <= w_code_now;
      end
   end

   assign bus.ch_fault   = w_ch_fault;
   assign bus.call_fault = r_call;
   assign bus.ov_fault   = w_ov;
   assign bus.uv_fault   = w_uv;
   assign bus.tem_fault  = w_tem;
   assign bus.db_fault   = w_db;
   assign bus.fault      = w_fault;
   assign bus.first_code = !w_fault ? 4'(FC_NONE) : (r_fault_q ? r_code : w_code_now);

endmodule

// File: tb/tb_fault_monitor_n.sv
// Directed bench for fault_monitor_n: filters, watchdog, first-fault code, clear, async reset.
module tb_fault_monitor_n;
   import fault_mon_pkg::*;

   localparam int NCH = 4;

   logic clk = 1'b0;
   logic rst;
   int   n_tests = 0;
   int   n_fail  = 0;

   fault_monitor_n_if #(.NCH(NCH)) bus ();

   fault_monitor_n #(
      .NCH(NCH), .FILT_LEN(8), .WDOG_MAX(400), .SYNC_MISS_MAX(4),
      .CHK_BASE(5000), .CHK_STEP(10000)
   ) dut (
      .clk(clk), .rst(rst), .bus(bus)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_idle(input string tag);
      check(tag, {bus.ch_fault, bus.call_fault, bus.ov_fault, bus.uv_fault, bus.tem_fault,
                  bus.db_fault, bus.fault, bus.first_code}, 32'd0);
   endtask

   task automatic pulse_clr();
      bus.clr_fault = 1'b1;
      tick(1);
      bus.clr_fault = 1'b0;
   endtask

   // One carrier period ending on a tri_cnt==fre_data match cycle.
   task automatic carrier(input logic with_syn);
      bus.tri_cnt = 16'd0;
      bus.syn     = with_syn;
      tick(1);
      bus.syn     = 1'b0;
      tick(2);
      bus.tri_cnt = 16'd100;
      tick(1);
      bus.tri_cnt = 16'd0;
   endtask

   initial begin
      bus.start = 1'b0; bus.check = 1'b0; bus.syn = 1'b0; bus.rcvd = 1'b0;
      bus.clr_fault = 1'b0; bus.tri_cnt = 16'd0; bus.fre_data = 16'd100;
      bus.check_data = 16'd0; bus.tr = '1; bus.col = '0;
      bus.ov = 1'b0; bus.uv = 1'b0; bus.tem = 1'b0; bus.db = 1'b0;
      rst = 1'b1;
      tick(2);
      check_idle("reset_outputs");
      rst = 1'b0;

      // Switch feedback: 7 low cycles must not qualify, 8 must.
      bus.tr = 4'b1011;
      tick(7);
      check("tr2_7cyc", bus.ch_fault, 32'h0);
      bus.tr = 4'b1111;
      tick(1);
      check("tr2_7cyc_release", {bus.ch_fault, bus.fault}, 32'h0);
      bus.tr = 4'b1011;
      tick(7);
      check("tr2_pre", bus.ch_fault, 32'h0);
      tick(1);
      check("tr2_ch_fault", bus.ch_fault, 32'h4);
      check("tr2_fault", bus.fault, 32'h1);
      check("tr2_first_code", bus.first_code, 32'd6);
      bus.tr = 4'b1111;
      tick(2);
      check("tr2_latched", bus.ch_fault, 32'h4);
      check("tr2_code_held", bus.first_code, 32'd6);
      pulse_clr();
      check_idle("tr2_cleared");

      // Undervoltage warning: up/down integrator, never drives fault.
      bus.uv = 1'b1;
      tick(7);
      check("uv_7cyc", bus.uv_fault, 32'h0);
      tick(1);
      check("uv_set", {bus.uv_fault, bus.fault}, 32'h2);
      bus.uv = 1'b0;
      tick(7);
      check("uv_hold", bus.uv_fault, 32'h1);
      tick(1);
      check("uv_clear", {bus.uv_fault, bus.fault}, 32'h0);
      bus.db = 1'b1;
      tick(8);
      check("db_set", {bus.db_fault, bus.fault}, 32'h2);
      bus.db = 1'b0;
      tick(8);
      check("db_clear", bus.db_fault, 32'h0);

      // Asynchronous reset in the middle of a qualification.
      bus.tr = 4'b0111;
      tick(8);
      check("ch3_set", bus.ch_fault, 32'h8);
      check("ch3_code", bus.first_code, 32'd7);
      bus.tr = 4'b0110;
      tick(5);
      #2 rst = 1'b1;
      #1 check_idle("rst_async");
      @(negedge clk);
      rst = 1'b0;
      tick(7);
      check("restart_7cyc", bus.ch_fault, 32'h0);
      tick(1);
      check("restart_8cyc", bus.ch_fault, 32'h9);
      check("restart_code", bus.first_code, 32'd4);
      bus.tr = 4'b1111;
      pulse_clr();
      check_idle("restart_cleared");

      // Overvoltage and temperature together; clear only what is idle.
      bus.ov  = 1'b1;
      bus.tem = 1'b1;
      tick(8);
      check("ov_tem_set", {bus.ov_fault, bus.tem_fault}, 32'h3);
      check("ov_tem_code", bus.first_code, 32'd2);
      bus.tem = 1'b0;
      pulse_clr();
      check("clr_ov_held", {bus.ov_fault, bus.tem_fault}, 32'h2);
      check("clr_code_held", {bus.fault, bus.first_code}, 32'h12);
      bus.tem = 1'b1;
      tick(7);
      bus.clr_fault = 1'b1;
      tick(1);
      bus.clr_fault = 1'b0;
      check("tem_beats_clr", bus.tem_fault, 32'h1);
      bus.ov  = 1'b0;
      bus.tem = 1'b0;
      pulse_clr();
      check_idle("ov_tem_cleared");

      // Receive-line watchdog.
      bus.start = 1'b1;
      tick(1);
      bus.start = 1'b0;
      bus.rcvd  = 1'b1;
      tick(400);
      check("wdog_400", bus.call_fault, 32'h0);
      tick(1);
      check("wdog_call", bus.call_fault, 32'h1);
      check("wdog_code", {bus.fault, bus.first_code}, 32'h11);
      bus.rcvd = 1'b0;
      tick(1);
      pulse_clr();
      check_idle("wdog_cleared");

      // Carrier sync supervision.
      carrier(1'b0);
      carrier(1'b0);
      carrier(1'b0);
      tick(1);
      check("miss_3", bus.call_fault, 32'h0);
      carrier(1'b0);
      check("miss_4_pre", bus.call_fault, 32'h0);
      tick(1);
      check("miss_4_call", bus.call_fault, 32'h1);
      carrier(1'b1);
      carrier(1'b1);
      pulse_clr();
      check("sync_recover_clr", bus.call_fault, 32'h0);
      carrier(1'b1);
      carrier(1'b1);
      carrier(1'b1);
      carrier(1'b1);
      tick(1);
      check_idle("sync_ok");

      // Channel self-check sample point k=1 (CHK_BASE + CHK_STEP).
      bus.col        = 4'b1111;
      bus.check_data = 16'd15000;
      tick(1);
      bus.check_data = 16'd0;
`ifdef FAULT_MON_SELFTEST_EN
      check("st_col1111", bus.ch_fault, 32'h2);
      check("st_code", bus.first_code, 32'd5);
      pulse_clr();
      check("st_cleared", bus.ch_fault, 32'h0);
`else
      check("st_ignored", {bus.ch_fault, bus.fault}, 32'h0);
`endif
      bus.col        = 4'b1101;
      bus.check_data = 16'd15000;
      tick(1);
      bus.check_data = 16'd0;
      check("st_col1101", {bus.ch_fault, bus.fault}, 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/fault_monitor_n.md
FAULT_MONITOR_N -- requirements
Module: fault_monitor_n

Interface
REQ-001 SHALL have parameter NCH, default 4, number of switch channels (1..8).
REQ-002 SHALL have parameter FILT_LEN, default 8, debounce qualification length in clk cycles.
REQ-003 SHALL have parameter WDOG_MAX, default 400, rcvd-stuck timeout in cycles.
REQ-004 SHALL have parameter SYNC_MISS_MAX, default 4, allowed consecutive carrier periods without syn.
REQ-005 SHALL have parameters CHK_BASE, default 5000, and CHK_STEP, default 10000, self-check sample points.
REQ-006 SHALL have ports: clk in 1 clock; rst in 1 reset, asynchronous, active-high.
REQ-007 SHALL have ports: start, check, syn in 1 arm/sync pulses; rcvd in 1 comm receive line; clr_fault in 1 fault-clear pulse.
REQ-008 SHALL have ports: tri_cnt, fre_data, check_data in 16 carrier count, carrier period, self-check timer.
REQ-009 SHALL have ports: tr in NCH switch feedback, active-low fault; col in NCH collector sense; ov, uv, tem, db in 1 raw alarms.
REQ-010 SHALL have outputs: ch_fault out NCH; call_fault, ov_fault, uv_fault, tem_fault, db_fault out 1; fault out 1 summary; first_code out 4 first-fault cause.

Function
REQ-011 SHALL set internal ready on syn|start|check; only rst clears ready.
REQ-012 SHALL count consecutive rcvd-high cycles while ready, saturating at WDOG_MAX; rcvd low zeroes count; !ready zeroes count.
REQ-013 SHALL, at each carrier match (tri_cnt==fre_data) while ready, increment miss counter if no syn since previous match, else zero it; saturate at SYNC_MISS_MAX.
REQ-014 SHALL set call_fault the cycle after rcvd count==WDOG_MAX or miss count==SYNC_MISS_MAX; latched.
REQ-015 SHALL filter ~tr[k], ov, tem with latching filters: count up while input high, zero when low; output sets once count reaches FILT_LEN; stays set.
REQ-016 SHALL filter uv, db with up/down filters: up while high, down while low, saturating 0..FILT_LEN; output sets at FILT_LEN, clears at 0.
REQ-017 SHALL set ch_fault[k] when filtered ~tr[k] asserts.
REQ-018 SHALL form fault = call_fault|ov_fault|tem_fault|OR(ch_fault); uv_fault, db_fault are warnings excluded from fault.
REQ-019 SHALL capture first_code on the first cycle fault rises from 0: 1 call, 2 ov, 3 tem, 4+k ch_fault[k]; lowest code wins on simultaneous sources; 0 when no fault.
REQ-020 SHALL on clr_fault clear each latched fault (call_fault, ov_fault, tem_fault, ch_fault) and its filter/counter only if its raw cause is currently inactive; first_code clears when fault falls.
REQ-021 SHALL give a newly qualifying fault priority over clr_fault in the same cycle.

Reset
REQ-022 SHALL on rst drive all outputs 0, all counters 0, ready 0, independent of clk, including mid-filter or mid-self-check.

Configuration
REQ-023 SHALL, with FAULT_MON_SELFTEST_EN defined, at check_data==CHK_BASE+k*CHK_STEP (k<NCH) set ch_fault[k] if col[k]==1 and ch_fault[j] for any j!=k with col[j]==0.
REQ-024 SHALL, without FAULT_MON_SELFTEST_EN, ignore col and check_data; ch_fault derives only from tr filters.

Structure
REQ-025 SHALL place first_code enumeration and parameter defaults in package fault_mon_pkg.
REQ-026 SHALL implement all alarm filters via one sub-module fm_filter with parameter MODE (latch/updown) and LEN.

Verification
REQ-027 SHALL cover: tr[2]=0 for 8 cycles -> ch_fault[2]=1 next cycle, fault=1, first_code=6; tr[2]=0 for 7 cycles then 1 -> no fault.
REQ-028 SHALL cover: uv high 8 cycles -> uv_fault=1; uv low 8 cycles -> uv_fault=0; fault stays 0.
REQ-029 SHALL cover: ready, rcvd high 400 cycles -> call_fault=1; 4 carrier matches without syn -> call_fault=1; syn each period -> 0.
REQ-030 SHALL cover: ov and tem qualify same cycle -> first_code=2; clr_fault with ov still high -> ov_fault stays 1, tem_fault clears once tem low.
REQ-031 SHALL cover (SELFTEST_EN): check_data=15000, col=4'b1111 -> ch_fault[1]=1; col=4'b1101 -> no fault.
REQ-032 SHALL cover: rst asserted mid-qualification (count 5) -> all outputs 0 immediately, restart from 0.
